laser_shot_scheduler: RTL and testbench

//  Sequences the ship's two cannons (top, bottom). Each cannon owns one laser

---
 rtl/laser_shot_scheduler_if.sv | 32 +++
 rtl/laser_shot_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_laser_shot_scheduler.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/laser_shot_scheduler_if.sv
// Signal bundle between the button/VGA side and the laser shot scheduler.
// The master drives fire requests, frame timing and the pixel position;
// the slave returns grants, laser state, energy and the pixel-fill term.
interface laser_shot_scheduler_if #(
    parameter int ENERGY_W = 4
);
    logic                fire_top;
    logic                fire_bot;
    logic                frame_tick;
    logic [9:0]          hCount;
    logic [9:0]          vCount;
    logic                grant_top;
    logic                grant_bot;
    logic                top_active;
    logic                bot_active;
    logic [9:0]          top_y;
    logic [9:0]          bot_y;
    logic [ENERGY_W-1:0] energy;
    logic                laser_fill;

    modport master (
        output fire_top, fire_bot, frame_tick, hCount, vCount,
        input  grant_top, grant_bot, top_active, bot_active,
               top_y, bot_y, energy, laser_fill
    );

    modport slave (
        input  fire_top, fire_bot, frame_tick, hCount, vCount,
        output grant_top, grant_bot, top_active, bot_active,
               top_y, bot_y, energy, laser_fill
    );
endinterface

// File: rtl/laser_shot_scheduler.sv
// Laser shot scheduler: two cannon slots (top, bottom), each IDLE -> FLY ->
// COOLDOWN -> IDLE, sharing one regenerating energy pool. Fire requests are
// arbitrated round-robin; lasers advance one step per frame_tick. Laser state
// is registered; laser_fill is a combinational hit test for the current pixel.
module laser_shot_scheduler #(
    parameter int SPEED           = 4,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int ENERGY_W        = 4,
    parameter int ENERGY_MAX      = 15,
    parameter int SHOT_COST       = 4,
    parameter int TOP_START_Y     = 187,
    parameter int BOT_START_Y     = 365,
    parameter int TOP_LIMIT       = 35,
    parameter int BOT_LIMIT       = 515,
    parameter int LASER_X         = 464,
    parameter int LASER_HW        = 1,
    parameter int LASER_LEN       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    laser_shot_scheduler_if.slave bus
);
    localparam int CNT_W = $clog2(COOLDOWN_FRAMES + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLY      = 2'd1,
        COOLDOWN = 2'd2
    } slot_state_t;

    slot_state_t         top_state_q, top_state_nxt;
    slot_state_t         bot_state_q, bot_state_nxt;
    logic [9:0]          top_y_q, top_y_nxt;
    logic [9:0]          bot_y_q, bot_y_nxt;
    logic [CNT_W-1:0]    top_cnt_q, top_cnt_nxt;
    logic [CNT_W-1:0]    bot_cnt_q, bot_cnt_nxt;
    logic [ENERGY_W-1:0] energy_q, energy_nxt;
    logic                ptr_bot_q, ptr_bot_nxt;   // 1: bottom wins a tie
    logic                grant_top_q, grant_top_nxt;
    logic                grant_bot_q, grant_bot_nxt;

    logic                elig_top, elig_bot;
    logic [ENERGY_W:0]   energy_sum;
    logic                top_hit, bot_hit, col_hit;
    logic [10:0]         h_ext, v_ext, top_y_ext, bot_y_ext;

    // Arbitration: at most one grant per cycle, round-robin pointer breaks ties.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves
        // it unassigned; a missing default infers a latch.
        grant_top_nxt = 1'b0;
        grant_bot_nxt = 1'b0;
        ptr_bot_nxt   = ptr_bot_q;
        elig_top      = (top_state_q == IDLE) && bus.fire_top &&
                        (energy_q >= ENERGY_W'(SHOT_COST));
        elig_bot      = (bot_state_q == IDLE) && bus.fire_bot &&
                        (energy_q >= ENERGY_W'(SHOT_COST));
        if (elig_top && elig_bot) begin
            grant_top_nxt = !ptr_bot_q;
            grant_bot_nxt = ptr_bot_q;
        end else begin
            grant_top_nxt = elig_top;
            grant_bot_nxt = elig_bot;
        end
        if (grant_top_nxt) ptr_bot_nxt = 1'b1;
        if (grant_bot_nxt) ptr_bot_nxt = 1'b0;
    end

    // Top slot next state: launch on grant, climb each frame, then cool down.
    always_comb begin
        top_state_nxt = top_state_q;
        top_y_nxt     = top_y_q;
        top_cnt_nxt   = top_cnt_q;
        case (top_state_q)
            IDLE: begin
                if (grant_top_nxt) begin
                    top_state_nxt = FLY;
                    top_y_nxt     = 10'(TOP_START_Y);
                end
            end
            FLY: begin
                if (bus.frame_tick) begin
                    if (top_y_q < 10'(TOP_LIMIT + SPEED)) begin
                        top_state_nxt = COOLDOWN;
                        top_cnt_nxt   = CNT_W'(COOLDOWN_FRAMES);
                    end else begin
                        top_y_nxt = top_y_q - 10'(SPEED);
                    end
                end
            end
            COOLDOWN: begin
                if (bus.frame_tick) begin
                    if (top_cnt_q == CNT_W'(1)) top_state_nxt = IDLE;
                    else                        top_cnt_nxt   = top_cnt_q - CNT_W'(1);
                end
            end
            default: top_state_nxt = IDLE;
        endcase
    end

    // Bottom slot next state: mirror of the top slot, descending the screen.
    always_comb begin
        bot_state_nxt = bot_state_q;
        bot_y_nxt     = bot_y_q;
        bot_cnt_nxt   = bot_cnt_q;
        case (bot_state_q)
            IDLE: begin
                if (grant_bot_nxt) begin
                    bot_state_nxt = FLY;
                    bot_y_nxt     = 10'(BOT_START_Y);
                end
            end
            FLY: begin
                if (bus.frame_tick) begin
                    if (bot_y_q > 10'(BOT_LIMIT - SPEED)) begin
                        bot_state_nxt = COOLDOWN;
                        bot_cnt_nxt   = CNT_W'(COOLDOWN_FRAMES);
                    end else begin
                        bot_y_nxt = bot_y_q + 10'(SPEED);
                    end
                end
            end
            COOLDOWN: begin
                if (bus.frame_tick) begin
                    if (bot_cnt_q == CNT_W'(1)) bot_state_nxt = IDLE;
                    else                        bot_cnt_nxt   = bot_cnt_q - CNT_W'(1);
                end
            end
            default: bot_state_nxt = IDLE;
        endcase
    end

    // Energy pool: pay for a grant, regain one unit per frame, clamp at the ceiling.
    // A grant only happens with energy >= SHOT_COST, so the subtraction cannot wrap.
    always_comb begin
        energy_sum = {1'b0, energy_q};
        if (grant_top_nxt || grant_bot_nxt) energy_sum = energy_sum - (ENERGY_W+1)'(SHOT_COST);
        if (bus.frame_tick)                 energy_sum = energy_sum + (ENERGY_W+1)'(1);
        if (energy_sum > (ENERGY_W+1)'(ENERGY_MAX)) energy_nxt = ENERGY_W'(ENERGY_MAX);
        else                                        energy_nxt = energy_sum[ENERGY_W-1:0];
    end

    // State registers; reset aborts any flight and refills the pool.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: control registers get the asynchronous reset so the block is in
        // a known state from the first edge, even if rst arrives mid-flight.
        if (rst) begin
            top_state_q <= IDLE;
            bot_state_q <= IDLE;
            top_y_q     <= 10'(TOP_START_Y);
            bot_y_q     <= 10'(BOT_START_Y);
            top_cnt_q   <= '0;
            bot_cnt_q   <= '0;
            energy_q    <= ENERGY_W'(ENERGY_MAX);
            ptr_bot_q   <= 1'b0;
            grant_top_q <= 1'b0;
            grant_bot_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            top_state_q <= top_state_nxt;
            bot_state_q <= bot_state_nxt;
            top_y_q     <= top_y_nxt;
            bot_y_q     <= bot_y_nxt;
            top_cnt_q   <= top_cnt_nxt;
            bot_cnt_q   <= bot_cnt_nxt;
            energy_q    <= energy_nxt;
            ptr_bot_q   <= ptr_bot_nxt;
            grant_top_q <= grant_top_nxt;
            grant_bot_q <= grant_bot_nxt;
        end
    end

    // Pixel hit test in 11 bits so y+LASER_LEN-1 near the bottom edge cannot wrap.
    always_comb begin
        h_ext     = {1'b0, bus.hCount};
        v_ext     = {1'b0, bus.vCount};
        top_y_ext = {1'b0, top_y_q};
        bot_y_ext = {1'b0, bot_y_q};
        col_hit   = (h_ext >= 11'(LASER_X - LASER_HW)) && (h_ext <= 11'(LASER_X + LASER_HW));
        top_hit   = (top_state_q == FLY) && col_hit && (v_ext >= top_y_ext) &&
                    (v_ext <= top_y_ext + 11'(LASER_LEN - 1));
        bot_hit   = (bot_state_q == FLY) && col_hit && (v_ext >= bot_y_ext) &&
                    (v_ext <= bot_y_ext + 11'(LASER_LEN - 1));
    end

    assign bus.grant_top  = grant_top_q;
    assign bus.grant_bot  = grant_bot_q;
    assign bus.top_active = (top_state_q == FLY);
    assign bus.bot_active = (bot_state_q == FLY);
    assign bus.top_y      = top_y_q;
    assign bus.bot_y      = bot_y_q;
    assign bus.energy     = energy_q;
    assign bus.laser_fill = top_hit || bot_hit;
endmodule

// File: tb/tb_laser_shot_scheduler.sv
// Testbench for laser_shot_scheduler: directed scenarios plus randomized
// traffic. A reference model tracks each slot as "ticks since launch" and
// derives y, activity and idleness arithmetically; expected outputs are queued
// per cycle and compared by an independent monitor.
module tb_laser_shot_scheduler;
    localparam int SPEED     = 4;
    localparam int CD        = 8;
    localparam int COST      = 4;
    localparam int EMAX      = 15;
    localparam int TOP_START = 187;
    localparam int BOT_START = 365;
    localparam int TOP_LIMIT = 35;
    localparam int BOT_LIMIT = 515;
    localparam int LX        = 464;
    localparam int LHW       = 1;
    localparam int LLEN      = 8;
    // Number of frame_ticks that move a laser before it stops.
    localparam int N_TOP = (TOP_START - (TOP_LIMIT + SPEED)) / SPEED + 1;
    localparam int N_BOT = (BOT_LIMIT - SPEED - BOT_START) / SPEED + 1;

    typedef struct {
        int gt, gb, at, ab, ty, by, e, fill;
    } exp_t;

    logic clk;
    logic rst;
    laser_shot_scheduler_if #(.ENERGY_W(4)) bus ();

    laser_shot_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state.
    int m_busy[2];
    int m_t[2];
    int m_y[2];
    int m_e;
    int m_ptr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int start_y(input int s);
        return (s == 0) ? TOP_START : BOT_START;
    endfunction

    function automatic int n_fly(input int s);
        return (s == 0) ? N_TOP : N_BOT;
    endfunction

    function automatic int model_y(input int s);
        int k;
        k = (m_t[s] < n_fly(s)) ? m_t[s] : n_fly(s);
        return (s == 0) ? start_y(s) - SPEED * k : start_y(s) + SPEED * k;
    endfunction

    function automatic int m_active(input int s);
        return (m_busy[s] != 0 && m_t[s] <= n_fly(s)) ? 1 : 0;
    endfunction

    function automatic int m_fill(input int s, input int h, input int v);
        return (m_active(s) != 0 && h >= LX - LHW && h <= LX + LHW &&
                v >= m_y[s] && v <= m_y[s] + LLEN - 1) ? 1 : 0;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 2; s++) begin
            m_busy[s] = 0;
            m_t[s]    = 0;
            m_y[s]    = start_y(s);
        end
        m_e   = EMAX;
        m_ptr = 0;
    endfunction

    function automatic exp_t snapshot(input int g, input int h, input int v);
        exp_t x;
        x.gt   = (g == 0) ? 1 : 0;
        x.gb   = (g == 1) ? 1 : 0;
        x.at   = m_active(0);
        x.ab   = m_active(1);
        x.ty   = m_y[0];
        x.by   = m_y[1];
        x.e    = m_e;
        x.fill = (m_fill(0, h, v) != 0 || m_fill(1, h, v) != 0) ? 1 : 0;
        return x;
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input int ft, input int fb, input int tk, input int h, input int v);
        int fire[2];
        int elig[2];
        int g;
        @(negedge clk);
        bus.fire_top   = ft[0];
        bus.fire_bot   = fb[0];
        bus.frame_tick = tk[0];
        bus.hCount     = 10'(h);
        bus.vCount     = 10'(v);
        fire[0] = ft;
        fire[1] = fb;
        for (int s = 0; s < 2; s++)
            elig[s] = (m_busy[s] == 0 && fire[s] != 0 && m_e >= COST) ? 1 : 0;
        g = -1;
        if (elig[0] != 0 && elig[1] != 0) g = m_ptr;
        else if (elig[0] != 0)            g = 0;
        else if (elig[1] != 0)            g = 1;
        if (tk != 0) begin
            for (int s = 0; s < 2; s++) begin
                if (m_busy[s] != 0) begin
                    m_t[s]++;
                    m_y[s] = model_y(s);
                    if (m_t[s] >= n_fly(s) + 1 + CD) m_busy[s] = 0;
                end
            end
        end
        if (g >= 0) begin
            m_busy[g] = 1;
            m_t[g]    = 0;
            m_y[g]    = start_y(g);
            m_ptr     = 1 - g;
        end
        m_e = m_e - ((g >= 0) ? COST : 0) + ((tk != 0) ? 1 : 0);
        if (m_e > EMAX) m_e = EMAX;
        exp_q.push_back(snapshot(g, h, v));
    endtask

    // Asynchronous reset in the middle of a low clock phase; checked at once.
    task automatic reset_pulse(input int h, input int v);
        @(negedge clk);
        bus.fire_top   = 1'b0;
        bus.fire_bot   = 1'b0;
        bus.frame_tick = 1'b0;
        bus.hCount     = 10'(h);
        bus.vCount     = 10'(v);
        model_reset();
        exp_q.push_back(snapshot(-1, h, v));
        #2 rst = 1'b1;
        #1;
        check("async_rst_top_active", int'(bus.top_active), 0);
        check("async_rst_bot_active", int'(bus.bot_active), 0);
        check("async_rst_energy", int'(bus.energy), EMAX);
        check("async_rst_top_y", int'(bus.top_y), TOP_START);
        check("async_rst_bot_y", int'(bus.bot_y), BOT_START);
        check("async_rst_fill", int'(bus.laser_fill), 0);
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare DUT outputs with the queued expectation after every edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("grant_top", int'(bus.grant_top), x.gt);
                check("grant_bot", int'(bus.grant_bot), x.gb);
                check("top_active", int'(bus.top_active), x.at);
                check("bot_active", int'(bus.bot_active), x.ab);
                check("top_y", int'(bus.top_y), x.ty);
                check("bot_y", int'(bus.bot_y), x.by);
                check("energy", int'(bus.energy), x.e);
                check("laser_fill", int'(bus.laser_fill), x.fill);
            end else if (!rst) begin
                check("unexpected_grant", int'({bus.grant_top, bus.grant_bot}), 0);
            end
        end
    end

    initial begin
        int h, v, r;
        rst            = 1'b1;
        bus.fire_top   = 1'b0;
        bus.fire_bot   = 1'b0;
        bus.frame_tick = 1'b0;
        bus.hCount     = 10'd464;
        bus.vCount     = 10'd190;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state.
        check("reset_energy", int'(bus.energy), 15);
        check("reset_top_y", int'(bus.top_y), 187);
        check("reset_bot_y", int'(bus.bot_y), 365);
        check("reset_actives", int'({bus.top_active, bus.bot_active}), 0);
        check("reset_grants", int'({bus.grant_top, bus.grant_bot}), 0);
        check("reset_fill", int'(bus.laser_fill), 0);
        rst = 1'b0;

        // Single top shot, then one frame.
        step(1, 0, 0, 464, 190);
        settle();
        check("shot_grant_top", int'(bus.grant_top), 1);
        check("shot_top_active", int'(bus.top_active), 1);
        check("shot_top_y", int'(bus.top_y), 187);
        check("shot_energy", int'(bus.energy), 11);
        check("shot_fill", int'(bus.laser_fill), 1);
        step(0, 0, 1, 464, 190);
        settle();
        check("tick1_top_y", int'(bus.top_y), 183);
        check("tick1_energy", int'(bus.energy), 12);
        check("tick1_grant_off", int'(bus.grant_top), 0);

        // Both fire lines held from reset: top first, then bottom, then nothing.
        reset_pulse(464, 190);
        step(1, 1, 0, 464, 190);
        settle();
        check("both_c1_grants", int'({bus.grant_top, bus.grant_bot}), 2);
        check("both_c1_energy", int'(bus.energy), 11);
        step(1, 1, 0, 464, 190);
        settle();
        check("both_c2_grants", int'({bus.grant_top, bus.grant_bot}), 1);
        check("both_c2_energy", int'(bus.energy), 7);
        step(1, 1, 0, 464, 190);
        settle();
        check("both_c3_grants", int'({bus.grant_top, bus.grant_bot}), 0);
        check("both_c3_energy", int'(bus.energy), 7);

        // Reset while both lasers fly, then the fill window around y=187.
        reset_pulse(464, 190);
        step(1, 0, 0, 464, 190);
        settle();
        check("fill_at_187", int'(bus.laser_fill), 1);
        step(0, 0, 1, 464, 190);
        step(0, 0, 1, 464, 190);
        settle();
        check("fill_after_2_ticks", int'(bus.laser_fill), 0);

        // Full flight and cooldown of the top slot with fire_top held.
        reset_pulse(464, 190);
        step(1, 0, 0, 464, 190);
        for (int k = 1; k <= 47; k++) begin
            step(1, 0, 1, 464, 40);
            settle();
            if (k == 38) begin
                check("flight_top_y_35", int'(bus.top_y), 35);
                check("flight_active_38", int'(bus.top_active), 1);
            end
            if (k == 39) begin
                check("flight_inactive_39", int'(bus.top_active), 0);
                check("flight_hold_y_39", int'(bus.top_y), 35);
            end
            step(1, 0, 0, 464, 40);
            settle();
            check("regrant_after_cooldown", int'(bus.grant_top), (k == 47) ? 1 : 0);
        end

        // Randomized traffic with occasional mid-flight resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) != 0) h = int'($urandom_range(461, 467));
            else                           h = int'($urandom_range(0, 799));
            r = int'($urandom_range(0, 1));
            v = m_y[r] + int'($urandom_range(0, 11)) - 2;
            if (v < 0)    v = 0;
            if (v > 1023) v = 1023;
            if (i % 1000 == 999) reset_pulse(h, v);
            else step(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? 1 : 0, h, v);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
